// File: rtl/spart_rx_ctrl.sv
// Receive-side control for the SPART: baud tick generator, RDA edge capture,
// a small receive FIFO and the processor register interface.
module spart_rx_ctrl #(
   parameter int          DEPTH     = 4,
   parameter logic [15:0] RESET_DIV = 16'd162
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       iocs,
   input  logic       iorw,
   input  logic [1:0] ioaddr,
   input  logic [7:0] databus_in,
   output logic [7:0] databus_out,
   input  logic [7:0] rec_buff,
   input  logic       RDA,
   output logic       rxEnable,
   output logic       rx_avail,
   output logic       overrun
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CONE = (AW+1)'(1);
   localparam logic [AW-1:0] PONE = AW'(1);

   logic [7:0]    divLo_q, divHi_q;
   logic [15:0]   cnt_q;
   logic          rda_q;
   logic          overrun_q;
   logic [AW-1:0] wrPtr_q, rdPtr_q;
   logic [AW:0]   count_q;
   logic [7:0]    mem [DEPTH];

   logic          popReq, statusRd, divLoWr, divHiWr;
   logic          push, pushEff, popEff, drop;
   logic [15:0]   div;
   logic [AW:0]   count_d;
   logic          overrun_d;

   assign popReq   = iocs & iorw & (ioaddr == 2'b00);
   assign statusRd = iocs & iorw & (ioaddr == 2'b01);
   assign divLoWr  = iocs & ~iorw & (ioaddr == 2'b10);
   assign divHiWr  = iocs & ~iorw & (ioaddr == 2'b11);
   assign div      = {divHi_q, divLo_q};

   // A full FIFO still accepts a push when a real pop frees a slot on the same edge.
   assign push    = RDA & ~rda_q;
   assign popEff  = popReq & (count_q != '0);
   assign pushEff = push & ((count_q != FULL) | popEff);
   assign drop    = push & ~pushEff;

   always_comb begin
      count_d = count_q;
      case ({pushEff, popEff})
         2'b10:   count_d = count_q + CONE;
         2'b01:   count_d = count_q - CONE;
         default: count_d = count_q;
      endcase
   end

   // Set wins over the clear-on-status-read.
   always_comb begin
      overrun_d = overrun_q;
      if (drop)
         overrun_d = 1'b1;
      else if (statusRd)
         overrun_d = 1'b0;
   end

   // Baud counter reloads with the full new divisor on the edge of either byte write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         divLo_q <= RESET_DIV[7:0];
         divHi_q <= RESET_DIV[15:8];
         cnt_q   <= RESET_DIV;
      end else if (divLoWr) begin
         divLo_q <= databus_in;
         cnt_q   <= {divHi_q, databus_in};
      end else if (divHiWr) begin
         divHi_q <= databus_in;
         cnt_q   <= {databus_in, divLo_q};
      end else if (div == 16'd0) begin
         cnt_q <= 16'd0;
      end else if (cnt_q <= 16'd1) begin
         cnt_q <= div;
      end else begin
         cnt_q <= cnt_q - 16'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rda_q     <= 1'b0;
         overrun_q <= 1'b0;
         wrPtr_q   <= '0;
         rdPtr_q   <= '0;
         count_q   <= '0;
      end else begin
         rda_q     <= RDA;
         overrun_q <= overrun_d;
         count_q   <= count_d;
         if (pushEff)
            wrPtr_q <= wrPtr_q + PONE;
         if (popEff)
            rdPtr_q <= rdPtr_q + PONE;
      end
   end

   // Storage is left uninitialised; reset only clears the pointers and count.
   always_ff @(posedge clk) begin
      if (pushEff)
         mem[wrPtr_q] <= rec_buff;
   end

   always_comb begin
      databus_out = 8'h00;
      if (iocs && iorw) begin
         case (ioaddr)
            2'b00:   databus_out = (count_q != '0) ? mem[rdPtr_q] : 8'h00;
            2'b01:   databus_out = {overrun_q, 2'b00, 5'(count_q)};
            default: databus_out = 8'h00;
         endcase
      end
   end

   assign rxEnable = (cnt_q == 16'd1);
   assign rx_avail = (count_q != '0);
   assign overrun  = overrun_q;

endmodule

// File: tb/tb_spart_rx_ctrl.sv
// Scoreboard bench for spart_rx_ctrl: every processor read pushes its expected
// byte into a queue, and a negedge monitor compares whatever the DUT drives.
module tb_spart_rx_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       iocs, iorw;
   logic [1:0] ioaddr;
   logic [7:0] databus_in, databus_out, rec_buff;
   logic       RDA, rxEnable, rx_avail, overrun;

   int checks = 0;
   int passes = 0;
   logic [7:0] expQ [$];
   int readIdx = 0;

   spart_rx_ctrl #(.DEPTH(4), .RESET_DIV(16'd162)) dut (
      .clk(clk), .rst(rst), .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr),
      .databus_in(databus_in), .databus_out(databus_out), .rec_buff(rec_buff),
      .RDA(RDA), .rxEnable(rxEnable), .rx_avail(rx_avail), .overrun(overrun)
   );

   always #5 clk = ~clk;

   // Monitor: every read cycle consumes one expected byte from the scoreboard.
   always @(negedge clk) begin
      if (iocs && iorw) begin
         checks++;
         if (expQ.size() == 0) begin
            $display("[TB] FAIL unexpected_read#%0d addr=%0d got=%02h required=<none>",
                     readIdx, ioaddr, databus_out);
         end else begin
            logic [7:0] e;
            e = expQ.pop_front();
            if (databus_out === e)
               passes++;
            else
               $display("[TB] FAIL read#%0d addr=%0d got=%02h required=%02h",
                        readIdx, ioaddr, databus_out, e);
         end
         readIdx++;
      end
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual == expected)
         passes++;
      else
         $display("[TB] FAIL %s got=%0d required=%0d", name, actual, expected);
   endtask

   // One bus cycle, optionally with an RDA rising edge on the same clock edge.
   task automatic applyStimulus(input logic rw, input logic [1:0] addr, input logic [7:0] wdata,
                                input logic [7:0] expRd, input logic withPush,
                                input logic [7:0] pushByte);
      iocs = 1'b1; iorw = rw; ioaddr = addr; databus_in = wdata;
      if (withPush) begin
         RDA = 1'b1;
         rec_buff = pushByte;
      end
      if (rw)
         expQ.push_back(expRd);
      @(posedge clk); #1;
      iocs = 1'b0; iorw = 1'b0; ioaddr = 2'b00; RDA = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic cpuRead(input logic [1:0] addr, input logic [7:0] expRd);
      applyStimulus(1'b1, addr, 8'h00, expRd, 1'b0, 8'h00);
   endtask

   task automatic cpuWrite(input logic [1:0] addr, input logic [7:0] wdata);
      applyStimulus(1'b0, addr, wdata, 8'h00, 1'b0, 8'h00);
   endtask

   task automatic pulseRda(input logic [7:0] b, input int width);
      rec_buff = b;
      RDA = 1'b1;
      repeat (width) begin @(posedge clk); #1; end
      RDA = 1'b0;
      @(posedge clk); #1;
   endtask

   // Counts edges until rxEnable is seen high; an expired budget reports -1.
   task automatic waitTick(output int n);
      n = 0;
      for (int i = 0; i < 400; i++) begin
         @(posedge clk); #1;
         n++;
         if (rxEnable) return;
      end
      n = -1;
   endtask

   initial begin
      int n, hi;
      rst = 1'b1; iocs = 1'b0; iorw = 1'b0; ioaddr = 2'b00;
      databus_in = 8'h00; rec_buff = 8'h00; RDA = 1'b0;
      #1;
      checkOutput("reset_rxEnable", rxEnable, 0);
      checkOutput("reset_rx_avail", rx_avail, 0);
      checkOutput("reset_overrun", overrun, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      waitTick(n); checkOutput("first_tick_gap", n, 161);
      waitTick(n); checkOutput("tick_period_1", n, 162);
      waitTick(n); checkOutput("tick_period_2", n, 162);
      @(posedge clk); #1;
      checkOutput("tick_width", rxEnable, 0);

      cpuRead(2'b01, 8'h00);
      cpuRead(2'b10, 8'h00);

      cpuWrite(2'b10, 8'h04);
      cpuWrite(2'b11, 8'h00);
      waitTick(n); waitTick(n); checkOutput("div4_period_a", n, 4);
      waitTick(n); checkOutput("div4_period_b", n, 4);

      cpuWrite(2'b10, 8'h01);
      hi = 0;
      for (int i = 0; i < 3; i++) begin @(posedge clk); #1; hi += int'(rxEnable); end
      checkOutput("div1_every_cycle", hi, 3);

      cpuWrite(2'b10, 8'h00);
      hi = 0;
      for (int i = 0; i < 20; i++) begin @(posedge clk); #1; hi += int'(rxEnable); end
      checkOutput("div0_held_low", hi, 0);

      pulseRda(8'hA5, 2);
      checkOutput("a5_rx_avail", rx_avail, 1);
      cpuRead(2'b01, 8'h01);
      cpuRead(2'b00, 8'hA5);
      checkOutput("a5_drained_avail", rx_avail, 0);
      cpuRead(2'b01, 8'h00);

      for (int b = 1; b <= 5; b++) pulseRda(8'(b), 1);
      checkOutput("overrun_flag", overrun, 1);
      cpuRead(2'b01, 8'h84);
      cpuRead(2'b01, 8'h04);
      for (int b = 1; b <= 4; b++) cpuRead(2'b00, 8'(b));
      cpuRead(2'b00, 8'h00);

      pulseRda(8'h11, 1); pulseRda(8'h22, 1); pulseRda(8'h33, 1); pulseRda(8'h44, 1);
      applyStimulus(1'b1, 2'b00, 8'h00, 8'h11, 1'b1, 8'h77);
      cpuRead(2'b01, 8'h04);
      cpuRead(2'b00, 8'h22); cpuRead(2'b00, 8'h33);
      cpuRead(2'b00, 8'h44); cpuRead(2'b00, 8'h77);

      applyStimulus(1'b1, 2'b00, 8'h00, 8'h00, 1'b1, 8'h5C);
      cpuRead(2'b01, 8'h01);
      cpuRead(2'b00, 8'h5C);

      pulseRda(8'hC1, 1); pulseRda(8'hC2, 1); pulseRda(8'hC3, 1); pulseRda(8'hC4, 1);
      applyStimulus(1'b1, 2'b01, 8'h00, 8'h04, 1'b1, 8'hEE);
      cpuRead(2'b01, 8'h84);
      for (int b = 0; b < 4; b++) cpuRead(2'b00, 8'hC1 + 8'(b));

      cpuWrite(2'b10, 8'h09);
      for (int b = 1; b <= 5; b++) pulseRda(8'hD0 + 8'(b), 1);
      @(posedge clk); #1 rst = 1'b1;
      #1;
      checkOutput("midreset_rx_avail", rx_avail, 0);
      checkOutput("midreset_overrun", overrun, 0);
      checkOutput("midreset_rxEnable", rxEnable, 0);
      @(posedge clk); #1 rst = 1'b0;
      waitTick(n); checkOutput("div_restored_gap", n, 161);
      cpuRead(2'b01, 8'h00);
      cpuRead(2'b00, 8'h00);

      repeat (2) @(posedge clk);
      checkOutput("scoreboard_drained", expQ.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
